// File: rtl/key_debounce_sync_pkg.sv
// Shared constants and helpers for the push-button synchroniser / debouncer.
// Pins are active-low on the target board, so the idle level is 1.
package key_pkg;

   localparam logic KEY_IDLE_LEVEL          = 1'b1;
   localparam int   DEFAULT_DEBOUNCE_CYCLES = 500000;

   // Wide enough to hold DEBOUNCE_CYCLES itself; the counter stops at cycles-1.
   function automatic int cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/key_debounce_bit.sv
// One key bit: 2-FF synchroniser, stability counter and registered press/release strobes.
// A change is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
module key_debounce_bit
   import key_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic IDLE_LEVEL      = KEY_IDLE_LEVEL
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key_db,
   output logic press_stb,
   output logic release_stb
);

   localparam int              CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic          s1, s2;
   logic [CW-1:0] cnt, cnt_next;
   logic          db_next, press_next, release_next;

   always_comb begin
      cnt_next     = '0;
      db_next      = key_db;
      press_next   = 1'b0;
      release_next = 1'b0;
      if (s2 != key_db) begin
         if (cnt == CNT_MAX) begin
            db_next      = s2;
            press_next   = (s2 != IDLE_LEVEL);
            release_next = (s2 == IDLE_LEVEL);
         end else begin
            cnt_next = cnt + 1'b1;
         end
      end
   end

   // Reset forces idle everywhere, so no strobe can come out of it.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1          <= IDLE_LEVEL;
         s2          <= IDLE_LEVEL;
         key_db      <= IDLE_LEVEL;
         cnt         <= '0;
         press_stb   <= 1'b0;
         release_stb <= 1'b0;
      end else begin
         s1          <= key_raw;
         s2          <= s1;
         key_db      <= db_next;
         cnt         <= cnt_next;
         press_stb   <= press_next;
         release_stb <= release_next;
      end
   end

endmodule

// File: rtl/key_debounce_sync.sv
// Synchronises and debounces WIDTH independent push-button pins; one bit slice per key.
module key_debounce_sync
   import key_pkg::*;
#(
   parameter int   WIDTH           = 2,
   parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter logic IDLE_LEVEL      = KEY_IDLE_LEVEL
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] key_raw,
   output logic [WIDTH-1:0] key_db,
   output logic [WIDTH-1:0] key_press,
   output logic [WIDTH-1:0] key_release
);

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      key_debounce_bit #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .IDLE_LEVEL      (IDLE_LEVEL)
      ) u_bit (
         .clk         (clk),
         .reset       (reset),
         .key_raw     (key_raw[g]),
         .key_db      (key_db[g]),
         .press_stb   (key_press[g]),
         .release_stb (key_release[g])
      );
   end

endmodule

// File: tb/tb_key_debounce_sync.sv
// Directed scenarios plus a random bounce phase, checked every cycle against a history-window model.
module tb_key_debounce_sync;

   localparam int W  = 2;
   localparam int DC = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] key_raw;
   logic [W-1:0] key_db, key_press, key_release;

   int checks = 0;
   int errors = 0;

   key_debounce_sync #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .IDLE_LEVEL(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .key_raw     (key_raw),
      .key_db      (key_db),
      .key_press   (key_press),
      .key_release (key_release)
   );

   always #5 clk = ~clk;

   // Model: raw is seen two samples late; a bit flips once its last DC delayed samples all disagree with it.
   logic [W-1:0] m_s1, m_s2, m_db, m_press, m_rel;
   bit           hist [W][$];

   function automatic bit stable_other(input int i);
      if (hist[i].size() < DC) return 1'b0;
      for (int k = hist[i].size() - DC; k < hist[i].size(); k++)
         if (hist[i][k] == m_db[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_edge(input logic [W-1:0] raw, input logic rst);
      m_press = '0;
      m_rel   = '0;
      if (rst) begin
         m_s1 = '1; m_s2 = '1; m_db = '1;
         for (int i = 0; i < W; i++) hist[i].delete();
      end else begin
         for (int i = 0; i < W; i++) begin
            hist[i].push_back(m_s2[i]);
            if (hist[i].size() > 64) void'(hist[i].pop_front());
            if (stable_other(i)) begin
               m_db[i] = ~m_db[i];
               if (m_db[i] == 1'b0) m_press[i] = 1'b1;
               else                 m_rel[i]   = 1'b1;
            end
         end
         m_s2 = m_s1;
         m_s1 = raw;
      end
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One clock: drive, edge, advance model, compare 1 time unit after the edge.
   task automatic tick(input logic [W-1:0] raw, input logic rst);
      key_raw = raw;
      reset   = rst;
      @(posedge clk);
      model_edge(raw, rst);
      #1;
      check("db",      key_db,      m_db);
      check("press",   key_press,   m_press);
      check("release", key_release, m_rel);
      check("excl",    key_press & key_release, '0);
   endtask

   int first, npress, nstrobe;
   logic [W-1:0] at_press, at_rel;
   logic db1_dropped;

   initial begin
      key_raw = '1;
      reset   = 1'b1;
      m_s1 = '1; m_s2 = '1; m_db = '1; m_press = '0; m_rel = '0;

      // 1: reset then idle hold
      tick(2'b11, 1'b1);
      tick(2'b11, 1'b1);
      for (int c = 0; c < 20; c++) tick(2'b11, 1'b0);
      check("t1_db", key_db, 2'b11);

      // 2: press key0, accepted at edge DC+2
      first = 0; at_press = '0;
      for (int e = 1; e <= 15; e++) begin
         tick(2'b10, 1'b0);
         if (first == 0 && key_db[0] == 1'b0) begin first = e; at_press = key_press; end
      end
      check("t2_edge", W'(first), W'(DC + 2));
      checks++;
      assert (first == DC + 2) else begin errors++; $error("FAIL t2_latency: observed %0d expected %0d", first, DC + 2); end
      check("t2_press", at_press, 2'b01);

      // 3: release, then bounce key0 in 3-cycle runs, then settle pressed
      for (int c = 0; c < 14; c++) tick(2'b11, 1'b0);
      npress = 0;
      for (int c = 0; c < 40; c++) begin
         tick({1'b1, ((c / 3) % 2) == 1}, 1'b0);
         npress += key_press[0];
      end
      check("t3_db_bounce", key_db, 2'b11);
      first = 0;
      for (int e = 1; e <= 15; e++) begin
         tick(2'b10, 1'b0);
         npress += key_press[0];
         if (first == 0 && key_db[0] == 1'b0) first = e;
      end
      checks++;
      assert (first == DC + 2) else begin errors++; $error("FAIL t3_latency: observed %0d expected %0d", first, DC + 2); end
      checks++;
      assert (npress == 1) else begin errors++; $error("FAIL t3_npress: observed %0d expected 1", npress); end

      // 4: both held, then released together
      for (int c = 0; c < 15; c++) tick(2'b00, 1'b0);
      check("t4_held", key_db, 2'b00);
      first = 0; at_rel = '0;
      for (int e = 1; e <= 15; e++) begin
         tick(2'b11, 1'b0);
         if (first == 0 && key_db == 2'b11) begin first = e; at_rel = key_release; end
      end
      checks++;
      assert (first == DC + 2) else begin errors++; $error("FAIL t4_latency: observed %0d expected %0d", first, DC + 2); end
      check("t4_release", at_rel, 2'b11);

      // 5: reset while key0 is mid-count (count 5 after edge 7)
      for (int e = 1; e <= 7; e++) tick(2'b10, 1'b0);
      tick(2'b10, 1'b1);
      check("t5_rst_db", key_db, 2'b11);
      check("t5_rst_stb", key_press | key_release, 2'b00);
      first = 0;
      for (int e = 1; e <= 15; e++) begin
         tick(2'b10, 1'b0);
         if (first == 0 && key_press[0]) first = e;
      end
      checks++;
      assert (first == DC + 2) else begin errors++; $error("FAIL t5_latency: observed %0d expected %0d", first, DC + 2); end

      // 6: 7-cycle low glitch on key1 (key0 held) is filtered
      nstrobe = 0; db1_dropped = 1'b0;
      for (int c = 0; c < 7; c++) begin
         tick(2'b00, 1'b0);
         nstrobe += $countones(key_press | key_release);
         db1_dropped |= ~key_db[1];
      end
      for (int c = 0; c < 14; c++) begin
         tick(2'b10, 1'b0);
         nstrobe += $countones(key_press | key_release);
         db1_dropped |= ~key_db[1];
      end
      check("t6_db1", {1'b0, db1_dropped}, 2'b00);
      checks++;
      assert (nstrobe == 0) else begin errors++; $error("FAIL t6_strobes: observed %0d expected 0", nstrobe); end

      // Random bounce with runs around the threshold and occasional resets
      begin
         logic [W-1:0] r;
         r = 2'b11;
         for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) r[0] = ~r[0];
            if ($urandom_range(0, 9) == 0) r[1] = ~r[1];
            tick(r, $urandom_range(0, 199) == 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
